// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the parity-protected serial link.
// Used by the receiver and by the future transmit side.
package serial_parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam bit PARITY_EVEN = 1'b0;
    localparam bit PARITY_ODD  = 1'b1;
    localparam bit START_BIT   = 1'b0;
    localparam bit STOP_BIT    = 1'b1;

endpackage

// File: rtl/serial_parity_rx_parity_accum.sv
// One-bit running-XOR register with clear and enable.
// The same block computes transmit-side parity.
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    // Running XOR register; clear wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/serial_parity_rx.sv
// Receiver: deserialises start/data/parity/stop frames clocked by bit_en
// strobes and reports parity and stop-bit errors with each completed word.
module serial_parity_rx #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    import serial_parity_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              state_r;
    state_t              state_nx_s;
    logic [CNT_W-1:0]    bit_cnt_r;
    logic [DATA_W-1:0]   shift_r;
    logic                perr_r;
    logic                acc_s;
    logic                acc_clr_s;
    logic                acc_en_s;
    logic                perr_ld_s;
    logic                done_s;
    logic                last_bit_s;

    assign last_bit_s = (bit_cnt_r == CNT_W'(DATA_W - 1));

    parity_accum u_parity_accum (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr_s),
        .en  (acc_en_s),
        .d   (rx_in),
        .acc (acc_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and per-strobe control decode; nothing moves without bit_en.
    always_comb begin
        state_nx_s = state_r;
        acc_clr_s  = 1'b0;
        acc_en_s   = 1'b0;
        perr_ld_s  = 1'b0;
        done_s     = 1'b0;
        if (bit_en) begin
            case (state_r)
                IDLE: begin
                    if (rx_in == START_BIT) begin
                        state_nx_s = DATA;
                        acc_clr_s  = 1'b1;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                DATA: begin
                    acc_en_s = 1'b1;
                    if (last_bit_s) begin
                        state_nx_s = PARITY;
                    end else begin
                        state_nx_s = DATA;
                    end
                end
                PARITY: begin
                    perr_ld_s  = 1'b1;
                    state_nx_s = STOP;
                end
                STOP: begin
                    done_s     = 1'b1;
                    state_nx_s = IDLE;
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // Datapath: bit counter, shift register, parity latch and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r  <= {CNT_W{1'b0}};
            shift_r    <= {DATA_W{1'b0}};
            perr_r     <= 1'b0;
            data_out   <= {DATA_W{1'b0}};
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= done_s;
            if (acc_clr_s) begin
                bit_cnt_r <= {CNT_W{1'b0}};
            end else if (acc_en_s) begin
                bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                // Shift in at the top; after DATA_W bits the first bit sits at bit 0.
                shift_r   <= DATA_W'({rx_in, shift_r} >> 1);
            end
            if (perr_ld_s) begin
                perr_r <= ((acc_s ^ rx_in) != PARITY_ODD);
            end
            if (acc_clr_s) begin
                busy <= 1'b1;
            end else if (done_s) begin
                busy       <= 1'b0;
                data_out   <= shift_r;
                parity_err <= perr_r;
                frame_err  <= ~rx_in;
            end
        end
    end

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed bench for serial_parity_rx: even-parity and odd-parity instances
// share one serial line; each scenario checks only the instance it targets.
module tb_serial_parity_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       rx_in = 1'b1;

    logic [7:0] e_data, o_data;
    logic       e_valid, e_perr, e_ferr, e_busy;
    logic       o_valid, o_perr, o_ferr, o_busy;

    int checks = 0;
    int errors = 0;
    int e_vcnt = 0;
    int o_vcnt = 0;
    int v0;

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in),
        .data_out(e_data), .data_valid(e_valid), .parity_err(e_perr),
        .frame_err(e_ferr), .busy(e_busy)
    );

    serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .bit_en(bit_en), .rx_in(rx_in),
        .data_out(o_data), .data_valid(o_valid), .parity_err(o_perr),
        .frame_err(o_ferr), .busy(o_busy)
    );

    // Count data_valid pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (e_valid) e_vcnt++;
        if (o_valid) o_vcnt++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One strobe, then `gap` idle cycles with random line noise.
    task automatic strobe(input logic b, input int gap);
        bit_en = 1'b1;
        rx_in  = b;
        @(posedge clk); #1;
        bit_en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            rx_in = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
        end
    endtask

    // Full frame; returns right after the stop-strobe edge (plus #1) when gap==0.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp, input int gap);
        strobe(1'b0, gap);
        for (int i = 0; i < 8; i++) strobe(d[i], gap);
        strobe(par, gap);
        bit_en = 1'b1;
        rx_in  = stp;
        @(posedge clk); #1;
        bit_en = 1'b0;
        rx_in  = 1'b1;
    endtask

    initial begin
        // Reset
        @(posedge clk); @(posedge clk); #1;
        check("rst_data",  16'(e_data), 16'h0000);
        check("rst_valid", 16'(e_valid), 16'h0);
        check("rst_perr",  16'(e_perr), 16'h0);
        check("rst_ferr",  16'(e_ferr), 16'h0);
        check("rst_busy",  16'(e_busy), 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Idle line keeps receiver idle
        strobe(1'b1, 0);
        check("idle_busy", 16'(e_busy), 16'h0);

        // 0xA5, parity 0, good stop, strobe every cycle
        v0 = e_vcnt;
        strobe(1'b0, 0);
        check("s1_busy_after_start", 16'(e_busy), 16'h1);
        for (int i = 0; i < 8; i++) strobe(((8'hA5 >> i) & 8'h01) != 8'h00, 0);
        strobe(1'b0, 0);
        check("s1_valid_before_stop", 16'(e_valid), 16'h0);
        bit_en = 1'b1; rx_in = 1'b1;
        @(posedge clk); #1;
        bit_en = 1'b0;
        check("s1_valid", 16'(e_valid), 16'h1);
        check("s1_data",  16'(e_data), 16'h00A5);
        check("s1_perr",  16'(e_perr), 16'h0);
        check("s1_ferr",  16'(e_ferr), 16'h0);
        check("s1_busy",  16'(e_busy), 16'h0);
        @(posedge clk); #1;
        check("s1_valid_drop", 16'(e_valid), 16'h0);
        check("s1_pulses", 16'(e_vcnt - v0), 16'h1);
        check("s1_data_hold", 16'(e_data), 16'h00A5);

        // 0xA5 with wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        check("s2_valid", 16'(e_valid), 16'h1);
        check("s2_data",  16'(e_data), 16'h00A5);
        check("s2_perr",  16'(e_perr), 16'h1);
        check("s2_ferr",  16'(e_ferr), 16'h0);
        @(posedge clk); #1;

        // 0x3C, correct parity, stop bit 0
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check("s3_valid", 16'(e_valid), 16'h1);
        check("s3_data",  16'(e_data), 16'h003C);
        check("s3_perr",  16'(e_perr), 16'h0);
        check("s3_ferr",  16'(e_ferr), 16'h1);
        @(posedge clk); #1;

        // 0xA5 with strobe every 4th cycle and noise between strobes
        v0 = e_vcnt;
        send_frame(8'hA5, 1'b0, 1'b1, 3);
        check("s4_valid", 16'(e_valid), 16'h1);
        check("s4_data",  16'(e_data), 16'h00A5);
        check("s4_perr",  16'(e_perr), 16'h0);
        check("s4_ferr",  16'(e_ferr), 16'h0);
        @(posedge clk); #1;
        check("s4_pulses", 16'(e_vcnt - v0), 16'h1);

        // Reset after 4 data bits (with a strobe in the reset cycle), then 0xFF
        v0 = e_vcnt;
        strobe(1'b0, 0);
        for (int i = 0; i < 4; i++) strobe(1'b1, 0);
        rst = 1'b1; bit_en = 1'b1; rx_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; bit_en = 1'b0; rx_in = 1'b1;
        check("s5_busy_after_rst", 16'(e_busy), 16'h0);
        check("s5_data_after_rst", 16'(e_data), 16'h0000);
        repeat (12) @(posedge clk);
        #1;
        check("s5_no_valid", 16'(e_vcnt - v0), 16'h0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        check("s5_valid", 16'(e_valid), 16'h1);
        check("s5_data",  16'(e_data), 16'h00FF);
        check("s5_perr",  16'(e_perr), 16'h0);
        check("s5_ferr",  16'(e_ferr), 16'h0);
        @(posedge clk); #1;

        // Odd parity: 0x01 then 0x80 back to back, parity bit 0 each
        v0 = o_vcnt;
        send_frame(8'h01, 1'b0, 1'b1, 0);
        check("s6a_valid", 16'(o_valid), 16'h1);
        check("s6a_data",  16'(o_data), 16'h0001);
        check("s6a_perr",  16'(o_perr), 16'h0);
        check("s6a_ferr",  16'(o_ferr), 16'h0);
        send_frame(8'h80, 1'b0, 1'b1, 0);
        check("s6b_valid", 16'(o_valid), 16'h1);
        check("s6b_data",  16'(o_data), 16'h0080);
        check("s6b_perr",  16'(o_perr), 16'h0);
        check("s6b_ferr",  16'(o_ferr), 16'h0);
        @(posedge clk); #1;
        check("s6_pulses", 16'(o_vcnt - v0), 16'h2);
        check("s6_busy",   16'(o_busy), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/serial_parity_rx.md
Name: serial_parity_rx

Overview:
- Receive end of the team's parity-protected serial link, where the transmit side XOR-folds each data word into a parity bit.
- Deserialises a framed bit stream and rebuilds the data word.
- Recomputes parity with a running XOR and checks it against the received parity bit; also checks the stop bit.
- Sits between the line sampler, which supplies one strobe per bit period, and the consumer logic.

Parameters:
DATA_W, 8, number of data bits per frame (legal range 1..16)
PARITY_ODD, 0, 0 = even parity expected, 1 = odd parity expected

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
bit_en  input  1  sample strobe; rx_in is consumed only in cycles where bit_en=1
rx_in  input  1  serial line; idles high
data_out  output  DATA_W  last received word, LSB received first
data_valid  output  1  one-cycle pulse: frame complete, data_out/errors updated
parity_err  output  1  parity mismatch on last completed frame
frame_err  output  1  stop bit was 0 on last completed frame
busy  output  1  high from the accepted start bit until the frame completes

Behaviour:
- Reset: while rst=1 at a clock edge, all outputs return to their reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0
  - state=IDLE, bit_cnt=0, parity accumulator=0
- Reset takes priority over bit_en in the same cycle.
- Frame format, one bit per bit_en strobe: start (0), DATA_W data bits LSB first, parity bit, stop (1).
- Cycles with bit_en=0 change no state; gaps between strobes are arbitrary.
- State machine:
  - IDLE: on bit_en with rx_in=0, go to DATA; clear bit_cnt and accumulator; busy=1 from the next cycle. On bit_en with rx_in=1, stay in IDLE.
  - DATA: on bit_en, write rx_in into shift register bit[bit_cnt]; acc ^= rx_in; bit_cnt++. When the strobe consumes bit DATA_W-1, go to PARITY.
  - PARITY: on bit_en, latch perr = (acc ^ rx_in) != PARITY_ODD; go to STOP.
  - STOP: on bit_en:
    - registered on that edge: data_out <= shift register, parity_err <= perr, frame_err <= ~rx_in, data_valid <= 1, busy <= 0
    - go to IDLE
- Latency: data_valid is high exactly the one cycle after the stop-bit strobe edge; it deasserts the following cycle unconditionally.
- data_valid pulses even when an error flag is set; the consumer decides what to do.
- data_out, parity_err and frame_err hold their values until the next data_valid or reset.
- Back-to-back frames: a start bit on the strobe immediately after the stop strobe is accepted. Worst case is bit_en=1 every cycle: the STOP→IDLE→DATA transition loses no bits.
- A false start (rx_in=0 for a single strobe) is not filtered; the frame is received and typically flags frame_err.
- Reset mid-frame: the partial frame is discarded with no data_valid; the next start bit begins a fresh frame.
- bit_cnt width is $clog2(DATA_W+1); it never wraps within a frame.

Decomposition:
- Package serial_parity_pkg holds:
  - state enum: IDLE, DATA, PARITY, STOP (2-bit encoding)
  - constants PARITY_EVEN=0, PARITY_ODD=1
  - START_BIT=0, STOP_BIT=1
- One sub-module, parity_accum: a 1-bit running-XOR register with clear and enable. It is shared with the future transmit side.

Test Plan:
- DATA_W=8, even parity, bit_en every cycle. Stream 0,1,0,1,0,0,1,0,1,0,1 (0xA5, parity 0) -> data_out=0xA5, data_valid single pulse, parity_err=0, frame_err=0, busy low after.
- Same frame with parity bit 1 -> data_out=0xA5, parity_err=1, frame_err=0.
- 0x3C with parity 0 and stop bit 0 -> data_out=0x3C, frame_err=1, parity_err=0.
- 0xA5 with bit_en every 4th cycle and rx_in toggling randomly between strobes -> identical result to the first scenario.
- rst pulsed after 4 data bits, then a clean 0xFF frame (parity 0) -> no valid for the aborted frame; then data_out=0xFF with both error flags 0.
- Two back-to-back frames 0x01 (parity 1) then 0x80 (parity 1), odd-parity build with PARITY_ODD=1 and parity bit 0 each -> two data_valid pulses, data_out 0x01 then 0x80, no errors.
